// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - SPART bus sequencer states, register addresses and baud divisor table
package spart_pkg;

    typedef enum logic [2:0] {
        LOAD_DBL,
        LOAD_DBH,
        WAIT_RX,
        READ_RX,
        WAIT_TX,
        WRITE_TX,
        GAP
    } state_t;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Indexed by br_cfg: 4800, 9600, 19200, 38400 baud
    function automatic logic [15:0] divisor_for(input logic [1:0] sel);
        case (sel)
            2'b00:   return 16'h028A;
            2'b01:   return 16'h0145;
            2'b10:   return 16'h00A2;
            default: return 16'h0050;
        endcase
    endfunction

endpackage

// File: rtl/spart_bus_sequencer_if.sv
// rtl/spart_bus_sequencer_if.sv - SPART control/handshake signals between sequencer and SPART
interface spart_bus_sequencer_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_db_tristate.sv
// rtl/spart_db_tristate.sv - bidirectional SPART data bus driver
module spart_db_tristate (
    input  logic [7:0] data,
    input  logic       oe,
    inout  wire  [7:0] databus,
    output logic [7:0] din
);
    assign databus = oe ? data : 8'hzz;
    assign din     = databus;
endmodule

// File: rtl/spart_bus_sequencer.sv
// rtl/spart_bus_sequencer.sv - programs the SPART baud divisor, then echoes every received byte
// Optional: SPART_SEQ_RECONFIG_EN enables reprogramming the divisor when br_cfg changes.
module spart_bus_sequencer
    import spart_pkg::*;
#(
    parameter int TX_GAP = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            br_cfg,
    spart_bus_sequencer_if.master bus,
    inout  wire  [7:0]            databus,
    output logic [7:0]            echo_cnt
);

    localparam logic [3:0] GAP_LAST  = 4'(TX_GAP - 1);
    localparam logic [1:0] BOOT_DONE = 2'd2;

    state_t      state;
    state_t      next_state;
    logic [1:0]  boot;
    logic [1:0]  cfg_q;
    logic [7:0]  rx_byte;
    logic [3:0]  gap_cnt;
    logic        cs;
    logic        rw;
    logic [1:0]  addr;
    logic        db_oe;
    logic [7:0]  db_out;
    logic [7:0]  db_in;
    logic [15:0] divisor;

`ifdef SPART_SEQ_RECONFIG_EN
    logic [1:0]  br_d1;
    logic [1:0]  pend_cfg;
    logic        pend;
    logic        reload;
`endif

    assign divisor    = divisor_for(cfg_q);
    assign bus.iocs   = cs;
    assign bus.iorw   = rw;
    assign bus.ioaddr = addr;

    spart_db_tristate u_db (
        .data    (db_out),
        .oe      (db_oe),
        .databus (databus),
        .din     (db_in)
    );

    // boot counts the release cycle plus the br_cfg sampling cycle; the bus stays idle until done
    always_comb begin
        next_state = state;
        cs         = 1'b0;
        rw         = 1'b1;
        addr       = ADDR_BUF;
        db_oe      = 1'b0;
        db_out     = 8'h00;
`ifdef SPART_SEQ_RECONFIG_EN
        reload     = 1'b0;
`endif
        if (boot == BOOT_DONE) begin
            case (state)
                LOAD_DBL: begin
                    cs         = 1'b1;
                    rw         = 1'b0;
                    addr       = ADDR_DBL;
                    db_oe      = 1'b1;
                    db_out     = divisor[7:0];
                    next_state = LOAD_DBH;
                end
                LOAD_DBH: begin
                    cs         = 1'b1;
                    rw         = 1'b0;
                    addr       = ADDR_DBH;
                    db_oe      = 1'b1;
                    db_out     = divisor[15:8];
                    next_state = WAIT_RX;
                end
                WAIT_RX: begin
                    if (bus.rda) next_state = READ_RX;
                end
                READ_RX: begin
                    cs         = 1'b1;
                    addr       = ADDR_BUF;
                    next_state = WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.tbr) next_state = WRITE_TX;
                end
                WRITE_TX: begin
                    cs         = 1'b1;
                    rw         = 1'b0;
                    addr       = ADDR_BUF;
                    db_oe      = 1'b1;
                    db_out     = rx_byte;
                    next_state = (TX_GAP > 0) ? GAP : WAIT_RX;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) next_state = WAIT_RX;
                end
                default: next_state = LOAD_DBL;
            endcase
`ifdef SPART_SEQ_RECONFIG_EN
            // A pending baud change diverts the next entry into WAIT_RX to a fresh divisor load
            if (pend && next_state == WAIT_RX && state != WAIT_RX) begin
                next_state = LOAD_DBL;
                reload     = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD_DBL;
            boot     <= 2'd0;
            cfg_q    <= 2'b00;
            rx_byte  <= 8'h00;
            gap_cnt  <= 4'd0;
            echo_cnt <= 8'h00;
        end else begin
            state <= next_state;
            if (boot != BOOT_DONE) boot <= boot + 2'd1;
            if (boot == 2'd1) cfg_q <= br_cfg;
`ifdef SPART_SEQ_RECONFIG_EN
            else if (reload) cfg_q <= pend_cfg;
`endif
            if (state == READ_RX) rx_byte <= db_in;
            if (state == WRITE_TX) echo_cnt <= echo_cnt + 8'd1;
            if (state == GAP) gap_cnt <= (gap_cnt == GAP_LAST) ? 4'd0 : gap_cnt + 4'd1;
        end
    end

`ifdef SPART_SEQ_RECONFIG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_d1    <= 2'b00;
            pend     <= 1'b0;
            pend_cfg <= 2'b00;
        end else begin
            br_d1 <= br_cfg;
            if (reload) begin
                pend <= 1'b0;
            end else if (boot == BOOT_DONE && br_cfg == br_d1 && br_cfg != cfg_q) begin
                pend     <= 1'b1;
                pend_cfg <= br_cfg;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spart_bus_sequencer.sv
// tb/tb_spart_bus_sequencer.sv - directed and randomized echo checks for spart_bus_sequencer
module tb_spart_bus_sequencer;

    localparam int TX_GAP_TB = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic [7:0] rd_data;
    logic [7:0] echo_cnt;
    wire  [7:0] databus;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_cnt  = 0;
    int n_done   = 0;

    // Bus observations, owned by the monitor
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         div_cnt = 0;
    int         last_wr_cyc = 0;
    logic [1:0] last_rd_addr = 2'b11;
    logic [7:0] wr_byte = 8'h00;
    bit         after_wr = 1'b0;
    bit         gap_arm = 1'b0;
    int         gap_min = 1000;
    int         gap_max = -1;

    spart_bus_sequencer_if bus ();

    spart_bus_sequencer #(.TX_GAP(TX_GAP_TB)) dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .bus      (bus),
        .databus  (databus),
        .echo_cnt (echo_cnt)
    );

    // SPART side: returns rd_data on buffer reads
    assign databus = (bus.iocs && bus.iorw) ? rd_data : 8'hzz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.iocs) begin
            if (bus.iorw) begin
                rd_cnt       <= rd_cnt + 1;
                last_rd_addr <= bus.ioaddr;
                after_wr     <= 1'b0;
                if (after_wr && gap_arm) begin
                    if (cyc - last_wr_cyc - 1 < gap_min) gap_min <= cyc - last_wr_cyc - 1;
                    if (cyc - last_wr_cyc - 1 > gap_max) gap_max <= cyc - last_wr_cyc - 1;
                end
            end else if (bus.ioaddr == 2'b00) begin
                wr_cnt      <= wr_cnt + 1;
                wr_byte     <= databus;
                last_wr_cyc <= cyc;
                after_wr    <= 1'b1;
            end else if (bus.ioaddr == 2'b10) begin
                div_cnt <= div_cnt + 1;
            end
        end
    end

    function automatic logic [15:0] baud_div(input logic [1:0] sel);
        case (sel)
            2'b00:   return 16'd650;
            2'b01:   return 16'd325;
            2'b10:   return 16'd162;
            default: return 16'd80;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_count(input string tag, input bit is_write, input int base, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if ((is_write ? wr_cnt : rd_cnt) >= base) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Called right after reset release, before any clock edge
    task automatic check_load(input string tag, input logic [1:0] cfg);
        logic [15:0] d;
        d = baud_div(cfg);
        chk({tag, "_idle0"}, 32'(bus.iocs), 32'd0);
        tick();
        chk({tag, "_idle1"}, 32'(bus.iocs), 32'd0);
        tick();
        chk({tag, "_dbl"}, {bus.iocs, bus.iorw, bus.ioaddr, databus}, {1'b1, 1'b0, 2'b10, d[7:0]});
        tick();
        chk({tag, "_dbh"}, {bus.iocs, bus.iorw, bus.ioaddr, databus}, {1'b1, 1'b0, 2'b11, d[15:8]});
        tick();
        chk({tag, "_waitrx"}, 32'(bus.iocs), 32'd0);
    endtask

    // One echo starting from WAIT_RX; returns once the sequencer is back in WAIT_RX
    task automatic echo(input string tag, input logic [7:0] b, input int tbr_delay, input bit pulse);
        int t0, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        rd_data = b;
        bus.rda = 1'b1;
        bus.tbr = (tbr_delay == 0);
        t0 = cyc;
        wait_count({tag, "_read"}, 1'b0, rd0 + 1, 20);
        bus.rda = 1'b0;
        chk({tag, "_raddr"}, 32'(last_rd_addr), 32'd0);
        for (int i = 0; i < tbr_delay; i++) begin
            bus.rda = pulse && (i == 5 || i == 12);
            tick();
        end
        bus.rda = 1'b0;
        chk({tag, "_one_read"}, 32'(rd_cnt - rd0), 32'd1);
        chk({tag, "_no_early_wr"}, 32'(wr_cnt - wr0), 32'd0);
        bus.tbr = 1'b1;
        wait_count({tag, "_write"}, 1'b1, wr0 + 1, 20);
        chk({tag, "_wdata"}, 32'(wr_byte), 32'(b));
        if (tbr_delay == 0) chk({tag, "_latency"}, 32'(last_wr_cyc - t0), 32'd3);
        bus.tbr = 1'b0;
        tick();
        n_done++;
        exp_cnt = n_done % 256;
        chk({tag, "_cnt"}, 32'(echo_cnt), 32'(exp_cnt));
        repeat (TX_GAP_TB) tick();
        chk({tag, "_one_write"}, 32'(wr_cnt - wr0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        br_cfg = 2'b01;
        rd_data = 8'h00;
        bus.rda = 1'b0;
        bus.tbr = 1'b0;
        repeat (3) tick();
        chk("rst_bus", {bus.iocs, bus.iorw, bus.ioaddr}, {1'b0, 1'b1, 2'b00});
        chk("rst_echo_cnt", 32'(echo_cnt), 32'd0);
        rst = 1'b0;
        check_load("boot", 2'b01);
`ifndef SPART_SEQ_RECONFIG_EN
        br_cfg = 2'b11;
`endif

        echo("echo5a", 8'h5A, 0, 1'b0);
        echo("tbr_hold", 8'hC3, 20, 1'b1);
        for (int k = 0; k < 30; k++)
            echo("rand", 8'($urandom), int'($urandom_range(0, 4)), 1'b0);

        // Back-to-back echoes up to 256 total so the counter wraps
        bus.rda = 1'b1;
        bus.tbr = 1'b1;
        rd_data = 8'h96;
        base = wr_cnt;
        wait_count("burst_first", 1'b1, base + 1, 20);
        gap_arm = 1'b1;
        wait_count("burst_done", 1'b1, base + (256 - n_done), 4000);
        gap_arm = 1'b0;
        bus.rda = 1'b0;
        bus.tbr = 1'b0;
        tick();
        n_done = 256;
        exp_cnt = n_done % 256;
        chk("wrap_cnt", 32'(echo_cnt), 32'(exp_cnt));
        // idle between write and next read = GAP cycles plus the WAIT_RX cycle that sees rda
        chk("gap_min", 32'(gap_min), 32'(TX_GAP_TB + 1));
        chk("gap_max", 32'(gap_max), 32'(TX_GAP_TB + 1));
        repeat (TX_GAP_TB + 2) tick();
`ifndef SPART_SEQ_RECONFIG_EN
        chk("cfg_change_ignored", 32'(div_cnt), 32'd1);
`endif

        // Reset asserted in the middle of a transmit write
        rd_data = 8'hA7;
        bus.rda = 1'b1;
        base = rd_cnt;
        wait_count("rst_mid_read", 1'b0, base + 1, 20);
        bus.rda = 1'b0;
        base = wr_cnt;
        bus.tbr = 1'b1;
        wait_count("rst_mid_write", 1'b1, base + 1, 20);
        rst = 1'b1;
        #1;
        chk("rst_mid_iocs", 32'(bus.iocs), 32'd0);
        chk("rst_mid_bus_released", 32'(databus === 8'hA7), 32'd0);
        chk("rst_mid_cnt", 32'(echo_cnt), 32'd0);
        bus.tbr = 1'b0;
        tick();
        rst = 1'b0;
        n_done = 0;
        check_load("reload", br_cfg);
        echo("post_rst", 8'h81, 0, 1'b0);

`ifdef SPART_SEQ_RECONFIG_EN
        rd_data = 8'h3C;
        bus.rda = 1'b1;
        base = rd_cnt;
        wait_count("recfg_read", 1'b0, base + 1, 20);
        bus.rda = 1'b0;
        br_cfg = 2'b11;
        repeat (4) tick();
        base = wr_cnt;
        bus.tbr = 1'b1;
        wait_count("recfg_write", 1'b1, base + 1, 20);
        chk("recfg_wdata", 32'(wr_byte), 32'h3C);
        bus.tbr = 1'b0;
        n_done++;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                if (bus.iocs) seen = 1'b1;
            end
            chk("recfg_seen", 32'(seen), 32'd1);
        end
        chk("recfg_dbl", {bus.iorw, bus.ioaddr, databus}, {1'b0, 2'b10, 8'h50});
        tick();
        chk("recfg_dbh", {bus.iorw, bus.ioaddr, databus}, {1'b0, 2'b11, 8'h00});
        chk("recfg_cnt", 32'(echo_cnt), 32'(n_done % 256));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
